// File: rtl/rst_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rst_ctrl_pkg
// Brief    : Shared types and helpers for the rst_ctrl_sonata reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package rst_ctrl_pkg;

  // Sequencer states, in the order a cold boot walks through them.
  typedef enum logic [1:0] {
    ST_STRETCH = 2'd0,
    ST_PERI    = 2'd1,
    ST_RUN     = 2'd2,
    ST_HOLD    = 2'd3
  } rst_state_e;

  // Cause of the most recent reset, as seen by software.
  typedef enum logic [1:0] {
    RstCauseExt = 2'd0,
    RstCauseNdm = 2'd1,
    RstCauseSw  = 2'd2
  } rst_cause_e;

  // Largest of three cycle counts; sizes the shared phase counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rst_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rst_sync
// Brief    : Reset synchroniser, asynchronous assertion and synchronous
//            release through a SyncStages-deep flop chain (SyncStages >= 2).
// Revision : 1.0 - initial release
// ============================================================================
module rst_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_no
);

  logic [SyncStages-1:0] sync_q;
  logic [SyncStages-1:0] sync_d;

  // Shift a constant 1 in from the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], 1'b1};
  end

  // Any low level on rst_ni empties the chain at once; release ripples through.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_no = sync_q[SyncStages-1];

endmodule
`default_nettype wire

// File: rtl/rst_ctrl_sonata.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rst_ctrl_sonata
// Brief    : Reset sequencer: synchronises the board reset, releases the
//            peripheral fabric then the Ibex core, handles ndmreset and
//            software soft resets and records the last reset cause.
//            Build option RST_CTRL_SW_RST_EN enables the software request;
//            without it sw_rst_req_i is present but ignored.
// Revision : 1.0 - initial release
// ============================================================================
module rst_ctrl_sonata
  import rst_ctrl_pkg::*;
#(
  parameter int unsigned SyncStages      = 2,
  parameter int unsigned StretchCycles   = 16,
  parameter int unsigned CoreDelayCycles = 4,
  parameter int unsigned HoldCycles      = 8
) (
  input  logic       clk_sys_i,
  input  logic       rst_sys_ni,
  input  logic       ndmreset_req_i,
  input  logic       sw_rst_req_i,
  output logic       rst_peri_no,
  output logic       rst_core_no,
  output logic       rst_done_o,
  output logic [1:0] rst_cause_o
);

  localparam int unsigned c_max_cycles = max3(StretchCycles, CoreDelayCycles, HoldCycles);
  localparam int unsigned c_cnt_w      = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;

  localparam logic [c_cnt_w-1:0] c_stretch_last = c_cnt_w'(StretchCycles - 1);
  localparam logic [c_cnt_w-1:0] c_core_last    = c_cnt_w'(CoreDelayCycles - 1);
  localparam logic [c_cnt_w-1:0] c_hold_last    = c_cnt_w'(HoldCycles - 1);

  logic               rst_sync_n;
  logic               sw_hit;
  rst_state_e         state_q, state_d;
  rst_cause_e         cause_q, cause_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               peri_n_q, peri_n_d;
  logic               core_n_q, core_n_d;
  logic               done_q, done_d;

  rst_sync #(
    .SyncStages (SyncStages)
  ) u_rst_sync (
    .clk_i  (clk_sys_i),
    .rst_ni (rst_sys_ni),
    .rst_no (rst_sync_n)
  );

`ifdef RST_CTRL_SW_RST_EN
  assign sw_hit = sw_rst_req_i;
`else
  logic unused_sw_req;
  assign unused_sw_req = sw_rst_req_i;
  assign sw_hit        = 1'b0;
`endif

  // Next-state, counter and cause logic; outputs are decoded from the next state
  // so that they register alongside it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_STRETCH: begin
        if (ndmreset_req_i) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          cause_d = RstCauseNdm;
        end else if (cnt_q == c_stretch_last) begin
          state_d = ST_PERI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PERI: begin
        if (ndmreset_req_i) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          cause_d = RstCauseNdm;
        end else if (cnt_q == c_core_last) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        // ndmreset has priority when both requests arrive together.
        if (ndmreset_req_i) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          cause_d = RstCauseNdm;
        end else if (sw_hit) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          cause_d = RstCauseSw;
        end
      end
      ST_HOLD: begin
        // Counter parks at its last value while ndmreset is still held.
        if (cnt_q == c_hold_last) begin
          if (!ndmreset_req_i) begin
            state_d = ST_STRETCH;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_STRETCH;
        cnt_d   = '0;
      end
    endcase

    peri_n_d = (state_d == ST_PERI) || (state_d == ST_RUN);
    core_n_d = (state_d == ST_RUN);
    done_d   = (state_d == ST_RUN);
  end

  // Sequencer state and registered outputs, all cleared by the synchronised reset.
  always_ff @(posedge clk_sys_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q  <= ST_STRETCH;
      cnt_q    <= '0;
      cause_q  <= RstCauseExt;
      peri_n_q <= 1'b0;
      core_n_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      peri_n_q <= peri_n_d;
      core_n_q <= core_n_d;
      done_q   <= done_d;
    end
  end

  assign rst_peri_no = peri_n_q;
  assign rst_core_no = core_n_q;
  assign rst_done_o  = done_q;
  assign rst_cause_o = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_ctrl_sonata.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rst_ctrl_sonata
// Brief    : Directed self-checking bench for rst_ctrl_sonata (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_ctrl_sonata;

  logic       clk;
  logic       rst_n;
  logic       ndm;
  logic       sw;
  logic       peri_n;
  logic       core_n;
  logic       done;
  logic [1:0] cause;

  int n_checks = 0;
  int n_fail   = 0;

  rst_ctrl_sonata dut (
    .clk_sys_i      (clk),
    .rst_sys_ni     (rst_n),
    .ndmreset_req_i (ndm),
    .sw_rst_req_i   (sw),
    .rst_peri_no    (peri_n),
    .rst_core_no    (core_n),
    .rst_done_o     (done),
    .rst_cause_o    (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    ndm   = 1'b0;
    sw    = 1'b0;

    // Power-on reset state.
    step(3);
    check("por_peri",  peri_n, 0);
    check("por_core",  core_n, 0);
    check("por_done",  done,   0);
    check("por_cause", cause,  0);

    // Release just before edge 1: peri at edge 18, core at edge 22.
    rst_n = 1'b1;
    step(17);
    check("boot_peri_e17", peri_n, 0);
    step(1);
    check("boot_peri_e18", peri_n, 1);
    check("boot_core_e18", core_n, 0);
    step(3);
    check("boot_core_e21", core_n, 0);
    step(1);
    check("boot_core_e22", core_n, 1);
    check("boot_done_e22", done,   1);
    check("boot_cause",    cause,  0);

    // Software request while running.
    sw = 1'b1;
    step(1);
    sw = 1'b0;
`ifdef RST_CTRL_SW_RST_EN
    check("sw_peri_entry",  peri_n, 0);
    check("sw_core_entry",  core_n, 0);
    check("sw_done_entry",  done,   0);
    check("sw_cause",       cause,  2);
    step(23);
    check("sw_peri_e23",    peri_n, 0);
    step(1);
    check("sw_peri_e24",    peri_n, 1);
    check("sw_core_e24",    core_n, 0);
    step(3);
    check("sw_core_e27",    core_n, 0);
    step(1);
    check("sw_core_e28",    core_n, 1);
    check("sw_done_e28",    done,   1);
    check("sw_cause_kept",  cause,  2);
`else
    check("swoff_peri",  peri_n, 1);
    check("swoff_core",  core_n, 1);
    check("swoff_done",  done,   1);
    check("swoff_cause", cause,  0);
    step(10);
    check("swoff_done_later", done, 1);
`endif

    // ndmreset held for 30 cycles: release 16+4 after it drops.
    ndm = 1'b1;
    step(1);
    check("ndm_peri_entry", peri_n, 0);
    check("ndm_done_entry", done,   0);
    check("ndm_cause",      cause,  1);
    step(29);
    check("ndm_peri_held",  peri_n, 0);
    check("ndm_core_held",  core_n, 0);
    ndm = 1'b0;
    step(16);
    check("ndm_peri_e45",   peri_n, 0);
    step(1);
    check("ndm_peri_e46",   peri_n, 1);
    check("ndm_core_e46",   core_n, 0);
    step(4);
    check("ndm_core_e50",   core_n, 1);
    check("ndm_done_e50",   done,   1);
    check("ndm_cause_kept", cause,  1);

    // Both requests in one cycle: ndmreset wins, minimum hold applies.
    ndm = 1'b1;
    sw  = 1'b1;
    step(1);
    ndm = 1'b0;
    sw  = 1'b0;
    check("both_cause",    cause,  1);
    check("both_peri",     peri_n, 0);
    step(23);
    check("both_peri_e23", peri_n, 0);
    step(1);
    check("both_peri_e24", peri_n, 1);
    check("both_core_e24", core_n, 0);

    // Sub-cycle glitch on the board reset while in the peripheral phase.
    #2;
    rst_n = 1'b0;
    #1;
    check("glitch_peri",  peri_n, 0);
    check("glitch_core",  core_n, 0);
    check("glitch_done",  done,   0);
    check("glitch_cause", cause,  0);
    #2;
    rst_n = 1'b1;
    step(17);
    check("rest_peri_e17", peri_n, 0);
    step(1);
    check("rest_peri_e18", peri_n, 1);
    step(3);
    check("rest_core_e21", core_n, 0);
    step(1);
    check("rest_core_e22", core_n, 1);
    check("rest_done_e22", done,   1);
    check("rest_cause",    cause,  0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
